sprite_dma_ctrl: RTL and testbench

//  Sequences and shares the register bus of NUM_SPRITES sprite units (10 bytes each: 0-7 bitmap rows, 8 X, 9 Y).
//  On each vsync rising edge it DMA-copies one 16-byte-strided descriptor per sprite from main memory into the units.

---
 rtl/sprite_dma_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_sprite_dma_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_dma_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_dma_ctrl
//
// Purpose
//   Owns the shared register bus of NUM_SPRITES sprite units (10 bytes each:
//   rows 0-7, X at 8, Y at 9). On every vsync rising edge with dma_en set, it
//   copies one 16-byte-strided descriptor per sprite from main memory into the
//   sprite units. Outside DMA the CPU talks to the sprites directly through a
//   combinational pass-through. During DMA the CPU is stalled with cpu_wait.
//
// Ports
//   clk, reset            system clock; asynchronous active-low reset
//   vsync, dma_en         frame trigger (synchronous to clk) and its enable
//   dma_page              source page, sampled when a DMA starts
//   cpu_cs/rw/sel/addr/di CPU sprite-bus access (rw: 1 = write)
//   cpu_wait              CPU must hold its access and retry
//   mem_rd, mem_addr      memory read request {page, sprite, byte}, held until
//   mem_grant, mem_data     granted; data arrives the cycle after the grant
//   spr_cs/rw/addr/di     sprite bus (one-hot select, rw: 1 = write)
//   busy, done            DMA in progress / one-cycle pulse after the last write
//
// Configuration
//   SPRITE_DMA_MASK_EN    adds input spr_mask[NUM_SPRITES-1:0], sampled at DMA
//                         start; a set bit skips that sprite entirely. When
//                         every sprite is masked, the edge goes straight to DONE.
// -----------------------------------------------------------------------------
module sprite_dma_ctrl #(
    parameter int NUM_SPRITES = 4,
    parameter int SEL_W       = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   dma_en,
    input  logic [7:0]             dma_page,
    input  logic                   cpu_cs,
    input  logic                   cpu_rw,
    input  logic [SEL_W-1:0]       cpu_sel,
    input  logic [3:0]             cpu_addr,
    input  logic [7:0]             cpu_di,
    output logic                   cpu_wait,
    output logic                   mem_rd,
    output logic [15:0]            mem_addr,
    input  logic                   mem_grant,
    input  logic [7:0]             mem_data,
`ifdef SPRITE_DMA_MASK_EN
    input  logic [NUM_SPRITES-1:0] spr_mask,
`endif
    output logic [NUM_SPRITES-1:0] spr_cs,
    output logic                   spr_rw,
    output logic [3:0]             spr_addr,
    output logic [7:0]             spr_di,
    output logic                   busy,
    output logic                   done
);

    localparam logic [3:0] BYTE_LAST = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    // Lowest sprite index >= from whose skip bit is clear.
    // Result bit 4 flags that such a sprite exists; bits 3:0 hold its index.
    function automatic logic [4:0] f_next_spr(input logic [NUM_SPRITES-1:0] skip,
                                              input logic [4:0]             from);
        logic [4:0] res;
        res = 5'd0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if ((5'(i) >= from) && !skip[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_vsync_q;
    logic                     w_edge;
    logic                     w_start;
    logic [7:0]               r_page_q;
    logic [3:0]               r_spr_idx;
    logic [3:0]               r_byte_idx;
    logic [3:0]               w_spr_nxt;
    logic [3:0]               w_byte_nxt;
    logic [7:0]               r_data_q;
    logic [NUM_SPRITES-1:0]   w_skip_start;
    logic [NUM_SPRITES-1:0]   w_skip_run;
    logic [4:0]               w_first;
    logic [4:0]               w_next;

    assign w_edge  = vsync & ~r_vsync_q;
    // Edges seen while busy, or with dma_en low, are dropped, not queued.
    assign w_start = (r_state == ST_IDLE) && w_edge && dma_en;

`ifdef SPRITE_DMA_MASK_EN
    logic [NUM_SPRITES-1:0] r_mask_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask_q <= '0;
        end else if (w_start) begin
            r_mask_q <= spr_mask;
        end
    end

    assign w_skip_start = spr_mask;
    assign w_skip_run   = r_mask_q;
`else
    assign w_skip_start = '0;
    assign w_skip_run   = '0;
`endif

    assign w_first = f_next_spr(w_skip_start, 5'd0);
    assign w_next  = f_next_spr(w_skip_run, {1'b0, r_spr_idx} + 5'd1);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of the
    // order in which the simulator evaluates the blocks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next state and sprite/byte sequencing
    // ---------------------------------------------------------------------
    // NOTE: every signal is given a default before the case statement, so
    // no path leaves a combinational output unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_spr_nxt   = r_spr_idx;
        w_byte_nxt  = r_byte_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_byte_nxt = 4'd0;
                    if (w_first[4]) begin
                        w_spr_nxt   = w_first[3:0];
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_spr_nxt   = 4'd0;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (mem_grant) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (r_byte_idx == BYTE_LAST) begin
                    w_byte_nxt = 4'd0;
                    if (w_next[4]) begin
                        w_spr_nxt   = w_next[3:0];
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_spr_nxt   = 4'd0;
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_byte_nxt  = r_byte_idx + 4'd1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vsync_q  <= 1'b0;
            r_page_q   <= 8'd0;
            r_spr_idx  <= 4'd0;
            r_byte_idx <= 4'd0;
            r_data_q   <= 8'd0;
        end else begin
            r_vsync_q  <= vsync;
            r_spr_idx  <= w_spr_nxt;
            r_byte_idx <= w_byte_nxt;
            // The page is frozen for the whole transfer; later dma_page
            // changes only matter for the next frame.
            if (w_start) begin
                r_page_q <= dma_page;
            end
            if (r_state == ST_WAIT) begin
                r_data_q <= mem_data;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs and bus arbitration
    // ---------------------------------------------------------------------
    assign busy     = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_WRITE);
    assign done     = (r_state == ST_DONE);
    assign mem_rd   = (r_state == ST_REQ);
    // Built straight from the index registers, so it stays stable for as
    // long as a request waits for its grant.
    assign mem_addr = {r_page_q, r_spr_idx, r_byte_idx};
    assign cpu_wait = busy & cpu_cs;

    always_comb begin
        spr_cs   = '0;
        spr_rw   = 1'b0;
        spr_addr = 4'd0;
        spr_di   = 8'd0;
        if (r_state == ST_WRITE) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                spr_cs[i] = (r_spr_idx == 4'(i));
            end
            spr_rw   = 1'b1;
            spr_addr = r_byte_idx;
            spr_di   = r_data_q;
        end else if (!busy) begin
            // Pass-through: an out-of-range cpu_sel selects nothing, so the
            // access is silently dropped rather than stalled.
            for (int i = 0; i < NUM_SPRITES; i++) begin
                spr_cs[i] = cpu_cs && (32'(cpu_sel) == 32'(i));
            end
            spr_rw   = cpu_rw;
            spr_addr = cpu_addr;
            spr_di   = cpu_di;
        end
    end

endmodule

// File: tb/tb_sprite_dma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_dma_ctrl
//
// Directed bench for sprite_dma_ctrl with NUM_SPRITES=4 and SEL_W=3 (the wider
// select lets an out-of-range sprite index be driven). A small memory model
// answers granted reads with a fixed address-derived byte; a negedge monitor
// logs grants, DMA sprite writes and busy/done cycles for later comparison.
// -----------------------------------------------------------------------------
module tb_sprite_dma_ctrl;

    localparam int NS = 4;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b0;
    logic          dma_en = 1'b0;
    logic [7:0]    dma_page = 8'd0;
    logic          cpu_cs = 1'b0;
    logic          cpu_rw = 1'b0;
    logic [SW-1:0] cpu_sel = '0;
    logic [3:0]    cpu_addr = 4'd0;
    logic [7:0]    cpu_di = 8'd0;
    logic          cpu_wait;
    logic          mem_rd;
    logic [15:0]   mem_addr;
    logic          mem_grant = 1'b1;
    logic [7:0]    mem_data = 8'd0;
    logic [NS-1:0] spr_cs;
    logic          spr_rw;
    logic [3:0]    spr_addr;
    logic [7:0]    spr_di;
    logic          busy;
    logic          done;
`ifdef SPRITE_DMA_MASK_EN
    logic [NS-1:0] spr_mask = '0;
`endif

    always #5 clk = ~clk;

    sprite_dma_ctrl #(
        .NUM_SPRITES (NS),
        .SEL_W       (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .dma_en    (dma_en),
        .dma_page  (dma_page),
        .cpu_cs    (cpu_cs),
        .cpu_rw    (cpu_rw),
        .cpu_sel   (cpu_sel),
        .cpu_addr  (cpu_addr),
        .cpu_di    (cpu_di),
        .cpu_wait  (cpu_wait),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_grant (mem_grant),
        .mem_data  (mem_data),
`ifdef SPRITE_DMA_MASK_EN
        .spr_mask  (spr_mask),
`endif
        .spr_cs    (spr_cs),
        .spr_rw    (spr_rw),
        .spr_addr  (spr_addr),
        .spr_di    (spr_di),
        .busy      (busy),
        .done      (done)
    );

    // Contents of main memory as seen by the DMA.
    function automatic logic [7:0] mem_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Read data appears the cycle after a granted request; otherwise a filler.
    always @(posedge clk) begin
        if (mem_rd && mem_grant) mem_data <= mem_fn(mem_addr);
        else                     mem_data <= 8'hC3;
    end

    // Monitor
    int            busy_cnt = 0;
    int            done_cnt = 0;
    int            wait_err = 0;
    int            ovl_err  = 0;
    int            g_n = 0;
    int            w_n = 0;
    logic [15:0]   g_log  [256];
    logic [NS-1:0] w_cs   [256];
    logic [3:0]    w_addr [256];
    logic [7:0]    w_di   [256];
    logic          w_rw   [256];

    always @(negedge clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done && busy) ovl_err <= ovl_err + 1;
        if (busy && (cpu_wait !== cpu_cs)) wait_err <= wait_err + 1;
        if (mem_rd && mem_grant && g_n < 256) begin
            g_log[g_n] <= mem_addr;
            g_n        <= g_n + 1;
        end
        if (busy && spr_cs != '0 && w_n < 256) begin
            w_cs[w_n]   <= spr_cs;
            w_addr[w_n] <= spr_addr;
            w_di[w_n]   <= spr_di;
            w_rw[w_n]   <= spr_rw;
            w_n         <= w_n + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the done pulse, then steps past it.
    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        tick();
    endtask

    // Waits for a pending request at the given address.
    task automatic wait_req(input string tag, input logic [15:0] addr, input int budget);
        int n;
        n = 0;
        while (!(mem_rd === 1'b1 && mem_addr === addr) && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_req_addr"}, 32'(mem_addr), 32'(addr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0, d0, g0, w0, e0;
        logic [15:0] ea;
        int s, b;

        // ---------------- reset ----------------
        #3 reset = 1'b0;
        tick();
        tick();
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_done",     32'(done),     32'd0);
        check("rst_mem_rd",   32'(mem_rd),   32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        check("rst_spr_cs",   32'(spr_cs),   32'd0);
        reset = 1'b1;
        tick();

        // ---------------- idle pass-through ----------------
        cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_sel = 3'd2; cpu_addr = 4'd8; cpu_di = 8'h40;
        #1;
        check("pt_wr_cs",   32'(spr_cs),   32'b0100);
        check("pt_wr_rw",   32'(spr_rw),   32'd1);
        check("pt_wr_addr", 32'(spr_addr), 32'd8);
        check("pt_wr_di",   32'(spr_di),   32'h40);
        check("pt_wr_wait", 32'(cpu_wait), 32'd0);
        cpu_rw = 1'b0; cpu_sel = 3'd3; cpu_addr = 4'd9;
        #1;
        check("pt_rd_cs",   32'(spr_cs),   32'b1000);
        check("pt_rd_rw",   32'(spr_rw),   32'd0);
        cpu_sel = 3'd5;
        #1;
        check("pt_oor_cs",   32'(spr_cs),   32'd0);
        check("pt_oor_wait", 32'(cpu_wait), 32'd0);
        cpu_cs = 1'b0;
        tick();

        // ---------------- full DMA with CPU contention ----------------
        b0 = busy_cnt; d0 = done_cnt; g0 = g_n; w0 = w_n; e0 = wait_err;
        dma_en = 1'b1; dma_page = 8'h12;
        cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_sel = 3'd1; cpu_addr = 4'd3; cpu_di = 8'hEE;
        vsync = 1'b1;
        #1;
        // Edge cycle: CPU still owns the bus.
        check("edge_busy", 32'(busy),     32'd0);
        check("edge_wait", 32'(cpu_wait), 32'd0);
        check("edge_cs",   32'(spr_cs),   32'b0010);
        tick();
        check("t1_busy",     32'(busy),     32'd1);
        check("t1_mem_rd",   32'(mem_rd),   32'd1);
        check("t1_mem_addr", 32'(mem_addr), 32'h1200);
        check("t1_wait",     32'(cpu_wait), 32'd1);
        check("t1_spr_cs",   32'(spr_cs),   32'd0);
        // Page change and a second vsync edge mid-DMA must both be ignored.
        dma_page = 8'h77;
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        wait_done("full", 400);
        check("full_busy_cycles", 32'(busy_cnt - b0), 32'd120);
        check("full_done_cycles", 32'(done_cnt - d0), 32'd1);
        check("full_grants",      32'(g_n - g0),      32'd40);
        check("full_writes",      32'(w_n - w0),      32'd40);
        check("full_wait_err",    32'(wait_err - e0), 32'd0);
        check("full_done_busy",   32'(ovl_err),       32'd0);
        for (int k = 0; k < 40; k++) begin
            s  = k / 10;
            b  = k % 10;
            ea = {8'h12, 4'(s), 4'(b)};
            check($sformatf("full_gaddr_%0d", k), 32'(g_log[g0 + k]), 32'(ea));
            check($sformatf("full_wcs_%0d", k),   32'(w_cs[w0 + k]),   32'(1 << s));
            check($sformatf("full_waddr_%0d", k), 32'(w_addr[w0 + k]), 32'(b));
            check($sformatf("full_wdi_%0d", k),   32'(w_di[w0 + k]),   32'(mem_fn(ea)));
            check($sformatf("full_wrw_%0d", k),   32'(w_rw[w0 + k]),   32'd1);
        end
        // After done the CPU access goes through again.
        check("post_cs",   32'(spr_cs),   32'b0010);
        check("post_wait", 32'(cpu_wait), 32'd0);
        b0 = busy_cnt;
        repeat (5) tick();
        check("post_no_restart", 32'(busy_cnt - b0), 32'd0);
        cpu_cs = 1'b0;
        vsync  = 1'b0;
        tick();

        // ---------------- grant stall, then reset mid-DMA ----------------
        dma_page = 8'h34;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        wait_req("stall", 16'h3403, 50);
        mem_grant = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("stall_rd_%0d", k),   32'(mem_rd),   32'd1);
            check($sformatf("stall_addr_%0d", k), 32'(mem_addr), 32'h3403);
            check($sformatf("stall_cs_%0d", k),   32'(spr_cs),   32'd0);
        end
        mem_grant = 1'b1;
        tick();
        check("stall_wait_rd", 32'(mem_rd), 32'd0);
        check("stall_wait_cs", 32'(spr_cs), 32'd0);
        tick();
        check("stall_wr_cs",   32'(spr_cs),   32'b0001);
        check("stall_wr_addr", 32'(spr_addr), 32'd3);
        check("stall_wr_di",   32'(spr_di),   32'(mem_fn(16'h3403)));

        wait_req("abort", 16'h3414, 100);
        d0 = done_cnt;
        #2 reset = 1'b0;
        #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_mem_rd", 32'(mem_rd), 32'd0);
        check("abort_done",   32'(done),   32'd0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle",    32'(busy),          32'd0);

        // ---------------- vsync with dma_en=0 ----------------
        dma_en = 1'b0;
        b0 = busy_cnt; d0 = done_cnt;
        vsync = 1'b1;
        repeat (5) tick();
        check("dis_no_busy", 32'(busy_cnt - b0), 32'd0);
        check("dis_no_done", 32'(done_cnt - d0), 32'd0);
        vsync = 1'b0;
        tick();

`ifdef SPRITE_DMA_MASK_EN
        // ---------------- masked sprites ----------------
        dma_en = 1'b1; dma_page = 8'h56; spr_mask = 4'b0101;
        b0 = busy_cnt; d0 = done_cnt; w0 = w_n;
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        spr_mask = 4'b0000;
        wait_done("mask", 300);
        check("mask_writes",      32'(w_n - w0),      32'd20);
        check("mask_busy_cycles", 32'(busy_cnt - b0), 32'd60);
        check("mask_done_cycles", 32'(done_cnt - d0), 32'd1);
        for (int k = 0; k < 20; k++) begin
            s  = (k < 10) ? 1 : 3;
            b  = k % 10;
            ea = {8'h56, 4'(s), 4'(b)};
            check($sformatf("mask_wcs_%0d", k),   32'(w_cs[w0 + k]),   32'(1 << s));
            check($sformatf("mask_waddr_%0d", k), 32'(w_addr[w0 + k]), 32'(b));
            check($sformatf("mask_wdi_%0d", k),   32'(w_di[w0 + k]),   32'(mem_fn(ea)));
        end

        spr_mask = 4'b1111;
        b0 = busy_cnt;
        vsync = 1'b1;
        tick();
        check("allmask_done",   32'(done),   32'd1);
        check("allmask_busy",   32'(busy),   32'd0);
        check("allmask_mem_rd", 32'(mem_rd), 32'd0);
        vsync = 1'b0;
        tick();
        check("allmask_done_end",  32'(done),              32'd0);
        check("allmask_no_busy",   32'(busy_cnt - b0),     32'd0);
        spr_mask = 4'b0000;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
